// File: rtl/ins_fetch_rv32i.sv
// RV32I instruction fetch: sequential PC generation, credit-limited word requests,
// in-order response buffering and redirect flush ahead of the decoders.
module ins_fetch_rv32i #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_fault
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]           data_mem_q [FIFO_DEPTH];
    logic [31:0]           pc_mem_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem_q;

    logic [CNT_W:0] inflight_c;
    logic           credit_ok_c;
    logic           req_valid_c;
    logic           req_fire_c;
    logic           dropping_c;
    logic           push_c;
    logic           pop_c;
    logic [31:0]    redirect_pc_c;
    logic           unused_redirect_lsb;

    assign redirect_pc_c       = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Conservative credit: requests still to be dropped hold a slot too.
    assign inflight_c  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok_c = inflight_c < (CNT_W+1)'(FIFO_DEPTH);
    assign req_valid_c = rst_n & ~redirect_valid & credit_ok_c;
    assign req_fire_c  = req_valid_c & imem_req_ready;

    assign dropping_c = (drop_cnt_q != '0);
    assign push_c     = imem_resp_valid & ~dropping_c & ~redirect_valid;
    assign pop_c      = (count_q != '0) & ins_ready & ~redirect_valid;

    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = rst_n ? fetch_pc_q : RESET_PC;
    assign ins_valid      = rst_n & (count_q != '0);
    assign ins            = rst_n ? data_mem_q[rd_ptr_q] : 32'h0;
    assign ins_pc         = rst_n ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign ins_fault      = rst_n & err_mem_q[rd_ptr_q];

    // Next-state for PCs, credit counters and FIFO pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire_c) - CNT_W'(imem_resp_valid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (req_fire_c) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push_c) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (imem_resp_valid && dropping_c) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end

        // Everything still in flight after this cycle's response is stale.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_c;
            resp_pc_d  = redirect_pc_c;
            drop_cnt_d = outstanding_q - CNT_W'(imem_resp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Faulted fetches are stored as a zero word so decode never sees garbage.
    always_ff @(posedge clk) begin
        if (push_c) begin
            data_mem_q[wr_ptr_q] <= imem_resp_err ? 32'h0 : imem_resp_data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            err_mem_q[wr_ptr_q]  <= imem_resp_err;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_c && (count_q == CNT_W'(FIFO_DEPTH))));
    a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q >= drop_cnt_q);
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_c <= (CNT_W+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_ins_fetch_rv32i.sv
// Cycle-level bench for ins_fetch_rv32i: memory model with a request queue,
// and a scoreboard of expected decode-side instructions.
module tb_ins_fetch_rv32i;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        imem_resp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_fault;

    ins_fetch_rv32i #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_fault      (ins_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic        stale;
    } mem_ent_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    mem_ent_t    mem_q[$];
    exp_t        sb_q[$];
    logic [31:0] exp_pc = RST_PC;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          rdy_pct = 100;
    int          resp_pct = 100;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check before the edge, update models after it.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit rst);
        bit       fire, resp, pop;
        mem_ent_t ent;
        exp_t     e;
        rst_n          = !rst;
        ins_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if (!rst && mem_q.size() != 0 && $urandom_range(99) < resp_pct) begin
            imem_resp_valid = 1'b1;
            imem_resp_err   = err_en && (mem_q[0].addr == err_addr);
            imem_resp_data  = mem_q[0].addr ^ 32'hA5A5_0000;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (rst) begin
            check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check_eq("rst_req_addr", imem_req_addr, RST_PC);
            check_eq("rst_ins_valid", 32'(ins_valid), 32'd0);
            check_eq("rst_ins", ins, 32'h0);
            check_eq("rst_ins_pc", ins_pc, 32'h0);
            check_eq("rst_ins_fault", 32'(ins_fault), 32'd0);
        end else begin
            check_eq("req_valid", 32'(imem_req_valid),
                     32'(!redir && (mem_q.size() + sb_q.size() < DEPTH)));
            if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_pc);
            check_eq("ins_valid", 32'(ins_valid), 32'(sb_q.size() != 0));
            if (ins_valid && sb_q.size() != 0) begin
                check_eq("ins", ins, sb_q[0].ins);
                check_eq("ins_pc", ins_pc, sb_q[0].pc);
                check_eq("ins_fault", 32'(ins_fault), 32'(sb_q[0].fault));
            end
        end
        fire = imem_req_valid && imem_req_ready;
        resp = imem_resp_valid;
        pop  = ins_valid && ins_ready && !redir;
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
            sb_q.delete();
            exp_pc = RST_PC;
        end else begin
            if (pop && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                n_pop++;
            end
            if (resp) begin
                ent = mem_q.pop_front();
                if (!ent.stale && !redir) begin
                    e.ins   = ent.err ? 32'h0 : (ent.addr ^ 32'hA5A5_0000);
                    e.pc    = ent.addr;
                    e.fault = ent.err;
                    sb_q.push_back(e);
                end
            end
            if (fire) begin
                ent.addr  = exp_pc;
                ent.err   = err_en && (exp_pc == err_addr);
                ent.stale = 1'b0;
                mem_q.push_back(ent);
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            if (redir) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                sb_q.delete();
                exp_pc = {rpc[31:2], 2'b00};
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int acc0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Streaming from reset, PCs wrap past the top of the address space.
        repeat (30) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Decode stall: buffer fills, requests stop, resume later.
        cycle(1'b0, 1'b1, 32'h0, 1'b0);
        acc0 = n_acc;
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_accepts", 32'(n_acc - acc0), 32'd2);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while two requests are outstanding with no response yet.
        resp_pct = 0;
        cycle(1'b1, 1'b1, 32'h10, 1'b0);
        acc0 = n_acc;
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("redir_outstanding", 32'(n_acc - acc0), 32'd2);
        cycle(1'b1, 1'b1, 32'h203, 1'b0);
        resp_pct = 100;
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Access fault at 0x40.
        err_en   = 1'b1;
        err_addr = 32'h40;
        cycle(1'b1, 1'b1, 32'h3C, 1'b0);
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        err_en = 1'b0;

        // Back-to-back redirects with a slow memory.
        resp_pct = 50;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h1000, 1'b0);
        cycle(1'b1, 1'b1, 32'h2002, 1'b0);
        repeat (15) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Random ready, random redirects, wrap from reset, reset mid-burst.
        rdy_pct  = 50;
        resp_pct = 60;
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                cycle(1'b1, 1'b0, 32'h0, 1'b1);
                cycle(1'b1, 1'b0, 32'h0, 1'b1);
            end
            cycle(1'($urandom_range(1)), ($urandom_range(24) == 0), $urandom, 1'b0);
        end

        check_eq("delivered_any", 32'(n_pop > 50), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
